btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_conditioner_if.sv | 21 ++
 rtl/btn_conditioner.sv | 113 +++++++++++
 tb/tb_btn_conditioner.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/btn_conditioner_if.sv
// Signal bundle between the button conditioner and its consumer.
// The master drives raw buttons and the tick; the slave returns debounced levels and grants.
interface btn_conditioner_if;
    logic [4:0] btn_raw;
    logic       tick;
    logic [4:0] btn_level;
    logic [4:0] press_onehot;
    logic [2:0] press_idx;
    logic       press_valid;
    logic [7:0] merge_cnt;

    modport master (
        output btn_raw, tick,
        input  btn_level, press_onehot, press_idx, press_valid, merge_cnt
    );

    modport slave (
        input  btn_raw, tick,
        output btn_level, press_onehot, press_idx, press_valid, merge_cnt
    );
endinterface

// File: rtl/btn_conditioner.sv
// Five-button conditioner: synchronizes and debounces the raw buttons, then queues each
// press and hands them one at a time to a consumer that acknowledges with tick.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    btn_conditioner_if.slave  bus
);
    // The level flips on the edge where the counter would reach DEBOUNCE_CYCLES.
    localparam logic [9:0] DB_LAST = 10'(DEBOUNCE_CYCLES - 1);

    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] r_level;
    logic [9:0] r_cnt [5];
    logic [4:0] r_pending;
    logic [4:0] r_onehot;
    logic [2:0] r_idx;
    logic       r_valid;
    logic [7:0] r_mergeCnt;

    logic [4:0] w_done;
    logic [4:0] w_rise;
    logic [4:0] w_grantOh;
    logic [2:0] w_grantIdx;
    logic       w_load;
    logic [4:0] w_clear;
    logic [4:0] w_merge;
    logic [3:0] w_mergeNum;
    logic [8:0] w_mergeSum;

    always_comb begin
        w_done = '0;
        w_rise = '0;
        for (int i = 0; i < 5; i++) begin
            w_done[i] = (r_sync2[i] != r_level[i]) && (r_cnt[i] == DB_LAST);
            w_rise[i] = w_done[i] && r_sync2[i];
        end
    end

    always_comb begin
        w_grantOh  = '0;
        w_grantIdx = '0;
        // Scanning downward leaves the lowest set index as the final assignment.
        for (int i = 4; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_grantOh  = 5'b00001 << i;
                w_grantIdx = 3'(i);
            end
        end
    end

    always_comb begin
        w_load     = bus.tick || !r_valid;
        w_clear    = w_load ? w_grantOh : 5'b00000;
        w_merge    = w_rise & r_pending & ~w_clear;
        w_mergeNum = '0;
        for (int i = 0; i < 5; i++) begin
            w_mergeNum = w_mergeNum + {3'b000, w_merge[i]};
        end
        w_mergeSum = {1'b0, r_mergeCnt} + {5'b00000, w_mergeNum};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            for (int i = 0; i < 5; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= bus.btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 5; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_done[i]) begin
                    r_cnt[i]   <= '0;
                    r_level[i] <= r_sync2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 10'd1;
                end
            end
        end
    end

    // A new rise is ORed in after the grant clear, so a same-edge set survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_onehot   <= '0;
            r_idx      <= '0;
            r_valid    <= 1'b0;
            r_mergeCnt <= '0;
        end else begin
            r_pending  <= (r_pending & ~w_clear) | w_rise;
            r_mergeCnt <= w_mergeSum[8] ? 8'hFF : w_mergeSum[7:0];
            if (w_load) begin
                r_onehot <= w_grantOh;
                r_idx    <= w_grantIdx;
                r_valid  <= |w_grantOh;
            end
        end
    end

    assign bus.btn_level    = r_level;
    assign bus.press_onehot = r_onehot;
    assign bus.press_idx    = r_idx;
    assign bus.press_valid  = r_valid;
    assign bus.merge_cnt    = r_mergeCnt;
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with DEBOUNCE_CYCLES=4: a behavioural model is compared every
// cycle, and directed scenarios pin literal values at hand-computed edges.
module tb_btn_conditioner;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic rst;
    int   nAssert = 0;
    int   nFail   = 0;
    logic checkEn = 1'b0;

    btn_conditioner_if bus();

    btn_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [4:0]  mSync1;
    logic [4:0]  mSync2;
    logic [4:0]  mLevel;
    logic [4:0]  mPending;
    logic [31:0] mHist [5];
    int          mGrant = -1;
    int          mMerge = 0;

    // The level flips once the last DB synchronized samples all disagree with it.
    always @(posedge clk) begin
        logic [4:0]  rise;
        logic [31:0] mask;
        int          pick;
        if (rst) begin
            mSync1 = '0; mSync2 = '0; mLevel = '0; mPending = '0;
            mGrant = -1; mMerge = 0;
            for (int i = 0; i < 5; i++) mHist[i] = '0;
        end else begin
            rise = '0;
            mask = (32'd1 << DB) - 32'd1;
            for (int i = 0; i < 5; i++) begin
                mHist[i] = {mHist[i][30:0], mSync2[i]};
                if ((mHist[i] & mask) == (mLevel[i] ? 32'd0 : mask)) begin
                    rise[i]   = ~mLevel[i];
                    mLevel[i] = ~mLevel[i];
                end
            end
            mSync2 = mSync1;
            mSync1 = bus.btn_raw;
            if (bus.tick || mGrant < 0) begin
                pick = -1;
                for (int i = 4; i >= 0; i--) if (mPending[i]) pick = i;
                mGrant = pick;
                if (pick >= 0) mPending[pick] = 1'b0;
            end
            for (int i = 0; i < 5; i++) begin
                if (rise[i]) begin
                    if (mPending[i] && mMerge < 255) mMerge = mMerge + 1;
                    mPending[i] = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model btn_level", {3'b0, bus.btn_level}, {3'b0, mLevel});
            checkOutput("model press_onehot", {3'b0, bus.press_onehot},
                        (mGrant >= 0) ? 8'(1 << mGrant) : 8'd0);
            checkOutput("model press_idx", {5'b0, bus.press_idx},
                        (mGrant >= 0) ? 8'(mGrant) : 8'd0);
            checkOutput("model press_valid", {7'b0, bus.press_valid}, {7'b0, mGrant >= 0});
            checkOutput("model merge_cnt", bus.merge_cnt, 8'(mMerge));
        end
    end

    task automatic applyStimulus(input logic [4:0] raw, input logic tk);
        bus.btn_raw = raw;
        bus.tick    = tk;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic quiet();
        applyStimulus(5'b00000, 1'b1);
        waitEdges(12);
        applyStimulus(5'b00000, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(5'b11111, 1'b0);
        @(negedge clk);
        checkEn = 1'b1;
        checkOutput("reset level", {3'b0, bus.btn_level}, 8'h00);
        checkOutput("reset onehot", {3'b0, bus.press_onehot}, 8'h00);
        @(negedge clk);
        checkOutput("reset valid", {7'b0, bus.press_valid}, 8'h00);
        checkOutput("reset merge", bus.merge_cnt, 8'h00);
        rst = 1'b0;
        waitEdges(5);
        checkOutput("rel level edge4", {3'b0, bus.btn_level}, 8'h00);
        waitEdges(1);
        checkOutput("rel level edge5", {3'b0, bus.btn_level}, 8'h1F);
        checkOutput("rel valid edge5", {7'b0, bus.press_valid}, 8'h00);
        waitEdges(1);
        checkOutput("rel onehot edge6", {3'b0, bus.press_onehot}, 8'h01);
        checkOutput("rel idx edge6", {5'b0, bus.press_idx}, 8'h00);
        quiet();

        applyStimulus(5'b00100, 1'b0);
        waitEdges(5);
        checkOutput("single level edge4", {3'b0, bus.btn_level}, 8'h00);
        waitEdges(1);
        checkOutput("single level edge5", {3'b0, bus.btn_level}, 8'h04);
        checkOutput("single valid edge5", {7'b0, bus.press_valid}, 8'h00);
        waitEdges(1);
        checkOutput("single onehot", {3'b0, bus.press_onehot}, 8'h04);
        checkOutput("single idx", {5'b0, bus.press_idx}, 8'h02);
        checkOutput("single valid", {7'b0, bus.press_valid}, 8'h01);
        waitEdges(5);
        checkOutput("single held", {3'b0, bus.press_onehot}, 8'h04);
        applyStimulus(5'b00100, 1'b1);
        waitEdges(1);
        checkOutput("single consumed", {3'b0, bus.press_onehot}, 8'h00);
        quiet();

        applyStimulus(5'b00010, 1'b0);
        waitEdges(3);
        applyStimulus(5'b00000, 1'b0);
        waitEdges(10);
        checkOutput("bounce level", {3'b0, bus.btn_level}, 8'h00);
        checkOutput("bounce valid", {7'b0, bus.press_valid}, 8'h00);
        checkOutput("bounce merge", bus.merge_cnt, 8'h00);

        applyStimulus(5'b01001, 1'b0);
        waitEdges(7);
        checkOutput("simul first", {3'b0, bus.press_onehot}, 8'h01);
        applyStimulus(5'b01001, 1'b1);
        waitEdges(1);
        checkOutput("simul second", {3'b0, bus.press_onehot}, 8'h08);
        checkOutput("simul idx", {5'b0, bus.press_idx}, 8'h03);
        waitEdges(1);
        checkOutput("simul empty", {3'b0, bus.press_onehot}, 8'h00);
        quiet();

        applyStimulus(5'b01001, 1'b0);
        waitEdges(7);
        checkOutput("merge hold", {3'b0, bus.press_onehot}, 8'h01);
        applyStimulus(5'b00001, 1'b0);
        waitEdges(8);
        checkOutput("merge release", {3'b0, bus.btn_level}, 8'h01);
        applyStimulus(5'b01001, 1'b0);
        waitEdges(8);
        checkOutput("merge count", bus.merge_cnt, 8'h01);
        checkOutput("merge still", {3'b0, bus.press_onehot}, 8'h01);
        applyStimulus(5'b01001, 1'b1);
        waitEdges(1);
        checkOutput("merge grant", {3'b0, bus.press_onehot}, 8'h08);
        waitEdges(1);
        checkOutput("merge single", {3'b0, bus.press_onehot}, 8'h00);
        waitEdges(3);
        checkOutput("merge no extra", {7'b0, bus.press_valid}, 8'h00);
        quiet();

        applyStimulus(5'b00001, 1'b0);
        waitEdges(7);
        applyStimulus(5'b10101, 1'b0);
        waitEdges(8);
        checkOutput("abort pre onehot", {3'b0, bus.press_onehot}, 8'h01);
        rst = 1'b1;
        applyStimulus(5'b00000, 1'b0);
        waitEdges(2);
        checkOutput("abort in reset", {3'b0, bus.press_onehot}, 8'h00);
        rst = 1'b0;
        applyStimulus(5'b00000, 1'b1);
        waitEdges(12);
        checkOutput("abort no grant", {7'b0, bus.press_valid}, 8'h00);
        checkOutput("abort merge", bus.merge_cnt, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end
endmodule
